djb2_hash_engine: RTL and testbench

- Parametrised, streaming successor to the fixed 32-bit DJB2 state-revisit puzzle.
- Absorbs a byte stream under valid/ready and computes a DJB2-family hash with selectable width, seed, shift and combine mode.
- Returns the final hash through an output handshake.
- Tracks two events over the message:
  - visits to a programmable magic state, with a sticky collision flag at a threshold;
  - revisits of any recently held state, via a DEPTH-entry history buffer.
- Serves formal puzzles and hash-collision benches as a drop-in engine.

---
 rtl/djb2_hash_engine.sv | 123 ++++++++++++
 tb/tb_djb2_hash_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/djb2_hash_engine.sv
// Streaming DJB2-family hash engine with magic-state visit counting
// and revisit detection against a short history of previous states.
module djb2_hash_engine #(
    parameter int WIDTH       = 32,
    parameter int SEED        = 5381,
    parameter int SHIFT       = 5,
    parameter int MODE        = 0,
    parameter int DEPTH       = 4,
    parameter int MATCH_LIMIT = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] magic,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             hash_valid,
    input  logic             hash_ready,
    output logic [WIDTH-1:0] hash_out,
    output logic [CNT_W-1:0] match_count,
    output logic             collision,
    output logic             revisit
);

    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        DONE
    } fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] hist [DEPTH];
    logic [DEPTH-1:0] hist_vld;

    logic [WIDTH-1:0] mult;
    logic [WIDTH-1:0] byte_ext;
    logic [WIDTH-1:0] nxt;
    logic             hit;
    logic             accept;
    logic             restart;
    logic [CNT_W-1:0] cnt_new;

    assign accept   = in_valid && in_ready;
    assign restart  = start && (fsm == IDLE || fsm == DONE);
    assign byte_ext = WIDTH'(in_data);
    assign mult     = (state_q << SHIFT) + state_q;
    assign nxt      = (MODE == 1) ? (mult + byte_ext) : (mult ^ byte_ext);

    // The entry about to be shifted out is still part of the comparison.
    always_comb begin
        hit = (nxt == state_q);
        for (int i = 0; i < DEPTH; i++) begin
            if (hist_vld[i] && hist[i] == nxt) hit = 1'b1;
        end
    end

    always_comb begin
        cnt_new = match_count;
        if (nxt == magic && match_count != '1) cnt_new = match_count + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm         <= IDLE;
            state_q     <= SEED_W;
            hist_vld    <= '0;
            in_ready    <= 1'b0;
            hash_valid  <= 1'b0;
            hash_out    <= '0;
            match_count <= '0;
            collision   <= 1'b0;
            revisit     <= 1'b0;
        end else begin
            revisit <= 1'b0;
            if (restart) begin
                fsm         <= ABSORB;
                in_ready    <= 1'b1;
                state_q     <= SEED_W;
                hist_vld    <= '0;
                hash_valid  <= 1'b0;
                match_count <= (SEED_W == magic) ? CNT_W'(1) : '0;
                collision   <= (MATCH_LIMIT == 1) && (SEED_W == magic);
            end else begin
                unique case (fsm)
                    ABSORB: begin
                        if (accept) begin
                            state_q     <= nxt;
                            hist[0]     <= state_q;
                            hist_vld[0] <= 1'b1;
                            for (int i = 1; i < DEPTH; i++) begin
                                hist[i]     <= hist[i-1];
                                hist_vld[i] <= hist_vld[i-1];
                            end
                            revisit     <= hit;
                            match_count <= cnt_new;
                            if (32'(cnt_new) >= MATCH_LIMIT) collision <= 1'b1;
                            if (in_last) begin
                                fsm        <= DONE;
                                in_ready   <= 1'b0;
                                hash_out   <= nxt;
                                hash_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (hash_ready) begin
                            fsm        <= IDLE;
                            hash_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_djb2_hash_engine.sv
// Directed bench for djb2_hash_engine: default XOR, ADD mode and an
// 8-bit instance with SEED == magic share one stimulus stream.
module tb_djb2_hash_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        hash_ready = 1'b0;
    logic [31:0] magic0 = '0;
    logic [7:0]  magic2 = '0;

    logic        rdy0, rdy1, rdy2;
    logic        hv0, hv1, hv2;
    logic [31:0] ho0, ho1;
    logic [7:0]  ho2;
    logic [7:0]  mc0, mc1, mc2;
    logic        col0, col1, col2;
    logic        rev0, rev1, rev2;

    int n_checks = 0;
    int n_fail   = 0;
    logic rev0_seen;

    always #5 clock = ~clock;

    djb2_hash_engine u0 (
        .clock(clock), .reset(reset), .start(start), .magic(magic0),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_last(in_last), .hash_valid(hv0), .hash_ready(hash_ready),
        .hash_out(ho0), .match_count(mc0), .collision(col0),
        .revisit(rev0)
    );

    djb2_hash_engine #(.MODE(1)) u1 (
        .clock(clock), .reset(reset), .start(start), .magic(magic0),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_last(in_last), .hash_valid(hv1), .hash_ready(hash_ready),
        .hash_out(ho1), .match_count(mc1), .collision(col1),
        .revisit(rev1)
    );

    djb2_hash_engine #(.WIDTH(8), .SEED(0), .MATCH_LIMIT(2)) u2 (
        .clock(clock), .reset(reset), .start(start), .magic(magic2),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .in_last(in_last), .hash_valid(hv2), .hash_ready(hash_ready),
        .hash_out(ho2), .match_count(mc2), .collision(col2),
        .revisit(rev2)
    );

    // The default instance never sees a repeated state in this stimulus.
    always @(negedge clock) begin
        if (reset) rev0_seen <= 1'b0;
        else if (rev0) rev0_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input int gaps);
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_ready", rdy0, 0);
        check_eq("rst_hvalid", hv0, 0);
        check_eq("rst_hout", ho0, 0);
        check_eq("rst_count", mc0, 0);
        check_eq("rst_coll", col0, 0);
        check_eq("rst_rev", rev0, 0);

        // Single byte 'a'
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("abs_ready", rdy0, 1);
        check_eq("pre_hvalid", hv0, 0);
        send_byte(8'h61, 1'b1, 0);
        check_eq("a_hvalid", hv0, 1);
        check_eq("a_xor", ho0, 32'h0002B5C4);
        check_eq("a_add", ho1, 32'd177670);
        check_eq("a_ready", rdy0, 0);
        check_eq("a_norev", rev0_seen, 0);
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        check_eq("a_idle_hv", hv0, 0);
        check_eq("a_idle_rdy", rdy0, 0);

        // Magic tracking on the 8-bit instance (SEED == magic == 0)
        magic2 = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("m_start_cnt", mc2, 1);
        check_eq("m_start_col", col2, 0);
        send_byte(8'h00, 1'b0, 0);
        check_eq("m1_cnt", mc2, 2);
        check_eq("m1_col", col2, 1);
        check_eq("m1_rev", rev2, 1);
        check_eq("m1_state_hv", hv2, 0);
        send_byte(8'h00, 1'b1, 0);
        check_eq("m2_cnt", mc2, 3);
        check_eq("m2_col", col2, 1);
        check_eq("m2_rev", rev2, 1);
        check_eq("m2_hv", hv2, 1);
        check_eq("m2_hout", ho2, 8'h00);

        // Backpressure on the hash output
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_rev_pulse", rev2, 0);
            check_eq("bp_hv", hv0, 1);
            check_eq("bp_hout", ho0, 32'd5859909);
            check_eq("bp_ready", rdy0, 0);
            check_eq("bp_cnt", mc2, 3);
        end
        hash_ready = 1'b1;
        tick();
        hash_ready = 1'b0;
        check_eq("bp_release", hv0, 0);
        check_eq("bp_release8", hv2, 0);
        magic2 = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("rs_cnt", mc2, 0);
        check_eq("rs_col", col2, 0);

        // "ab" with input gaps
        send_byte(8'h61, 1'b0, 2);
        send_byte(8'h62, 1'b1, 3);
        check_eq("ab_hv", hv0, 1);
        check_eq("ab_xor", ho0, 32'h00596E26);
        check_eq("ab_add", ho1, 32'h00597728);
        check_eq("ab_norev", rev0_seen, 0);

        // Start in DONE beats a simultaneous hash accept
        start = 1'b1;
        hash_ready = 1'b1;
        tick();
        start = 1'b0;
        hash_ready = 1'b0;
        check_eq("prio_hv", hv0, 0);
        check_eq("prio_ready", rdy0, 1);

        // Reset after the first byte of a three-byte message
        send_byte(8'h31, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mr_ready", rdy0, 0);
        check_eq("mr_hv", hv0, 0);
        check_eq("mr_hout", ho0, 0);
        check_eq("mr_cnt", mc2, 0);
        check_eq("mr_col", col2, 0);
        in_valid = 1'b1;
        in_data  = 8'h32;
        for (int i = 0; i < 4; i++) begin
            in_last = (i == 3);
            tick();
            check_eq("mr_no_hv", hv0, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
